// File: rtl/trivium_keystream_core.sv
// trivium_keystream_core: Trivium keystream generator behind the Kin/Din/Krdy/Drdy/Kvld/Dvld/BSY handshake.
// Runs 1152 initialisation rounds, then returns 128 keystream bits (z1 at Dout[127]); UNROLL rounds per clock.
module trivium_keystream_core #(
    parameter int UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [79:0]  Kin,
    input  logic [79:0]  Din,
    input  logic         Krdy,
    input  logic         Drdy,
    input  logic         EncDec,
    output logic [127:0] Dout,
    output logic         BSY,
    output logic         Kvld,
    output logic         Dvld
);
    localparam logic [10:0] INIT_LAST = 11'(1152 / UNROLL - 1);
    localparam logic [10:0] GEN_LAST  = 11'(128 / UNROLL - 1);

    typedef enum logic [1:0] {IDLE, INIT, GEN} state_t;

    state_t            state_q;
    logic [287:0]      s_q, s_d;
    logic [79:0]       key_q;
    logic              key_loaded_q, kvld_q, dvld_q, bsy_q;
    logic [10:0]       cnt_q;
    logic [127:0]      acc_q, acc_d, dout_q;
    logic [UNROLL-1:0] z_d;
    logic [288:0]      rnd;
    logic              key_load, start, last;
    logic              unused_encdec;

    // Bit k of the vector holds Trivium state bit s(k+1); result is {z, next state}.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        return {t1 ^ t2 ^ t3,
                s[286:177], t1 ^ (s[90] & s[91]) ^ s[170],
                s[175:93],  t2 ^ (s[174] & s[175]) ^ s[263],
                s[91:0],    t3 ^ (s[285] & s[286]) ^ s[68]};
    endfunction

    function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] iv);
        logic [287:0] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]      = k[79-i];
            s[93 + i] = iv[79-i];
        end
        s[287:285] = 3'b111;
        return s;
    endfunction

    always_comb begin
        s_d = s_q;
        z_d = '0;
        rnd = '0;
        for (int r = 0; r < UNROLL; r++) begin
            rnd = trivium_round(s_d);
            s_d = rnd[287:0];
            z_d[UNROLL-1-r] = rnd[288];
        end
    end

    // Earliest keystream bit of each clock lands highest so z1 ends up at bit 127.
    assign acc_d         = {acc_q[127-UNROLL:0], z_d};
    assign key_load      = Krdy && !kvld_q;
    assign start         = Drdy && key_loaded_q && !key_load;
    assign last          = cnt_q == (state_q == INIT ? INIT_LAST : GEN_LAST);
    assign unused_encdec = EncDec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            s_q          <= '0;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            kvld_q       <= 1'b0;
            dvld_q       <= 1'b0;
            bsy_q        <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            dout_q       <= '0;
        end else if (EN) begin
            kvld_q <= 1'b0;
            dvld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_load) begin
                        key_q        <= Kin;
                        key_loaded_q <= 1'b1;
                        kvld_q       <= 1'b1;
                    end else if (start) begin
                        s_q     <= load_state(key_q, Din);
                        cnt_q   <= '0;
                        bsy_q   <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    s_q     <= s_d;
                    cnt_q   <= last ? '0 : cnt_q + 11'd1;
                    state_q <= last ? GEN : INIT;
                end
                GEN: begin
                    s_q   <= s_d;
                    acc_q <= acc_d;
                    cnt_q <= last ? '0 : cnt_q + 11'd1;
                    if (last) begin
                        dout_q  <= acc_d;
                        dvld_q  <= 1'b1;
                        bsy_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pulses stay pending in their registers while EN is low and appear once it returns.
    assign Dout = dout_q;
    assign BSY  = bsy_q;
    assign Kvld = kvld_q & EN;
    assign Dvld = dvld_q & EN;
endmodule

// File: tb/tb_trivium_keystream_core.sv
// tb_trivium_keystream_core: directed tests of the Trivium responder against a bit-serial model,
// with UNROLL=1, 8 and 64 instances sharing one set of inputs.
module tb_trivium_keystream_core;
    logic         clk = 1'b0;
    logic         rst, en, krdy, drdy, encdec;
    logic [79:0]  kin, din;
    logic [127:0] dout1, dout8, dout64;
    logic         bsy1, bsy8, bsy64, kvld1, kvld8, kvld64, dvld1, dvld8, dvld64;
    int           vectors = 0, miscompares = 0, kvld_pulses = 0;
    logic [79:0]  ivs [10];
    logic [79:0]  iv_basic = 80'h80000000000000000000;
    logic [127:0] exp_basic, e;
    int           n, n8, n64, k, p;
    logic         b0, be;

    trivium_keystream_core #(.UNROLL(1)) u1 (.CLK(clk), .RST(rst), .EN(en), .Kin(kin), .Din(din),
        .Krdy(krdy), .Drdy(drdy), .EncDec(encdec), .Dout(dout1), .BSY(bsy1), .Kvld(kvld1), .Dvld(dvld1));
    trivium_keystream_core #(.UNROLL(8)) u8 (.CLK(clk), .RST(rst), .EN(en), .Kin(kin), .Din(din),
        .Krdy(krdy), .Drdy(drdy), .EncDec(encdec), .Dout(dout8), .BSY(bsy8), .Kvld(kvld8), .Dvld(dvld8));
    trivium_keystream_core #(.UNROLL(64)) u64 (.CLK(clk), .RST(rst), .EN(en), .Kin(kin), .Din(din),
        .Krdy(krdy), .Drdy(drdy), .EncDec(encdec), .Dout(dout64), .BSY(bsy64), .Kvld(kvld64), .Dvld(dvld64));

    always #5 clk = ~clk;
    always @(negedge clk) if (kvld1) kvld_pulses++;

    function automatic logic [127:0] model(input logic [79:0] key, input logic [79:0] iv);
        logic [1:288] s;
        logic [127:0] res;
        logic t1, t2, t3, z;
        s = '0;
        res = '0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = key[80-i];
            s[93 + i] = iv[80-i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 1; r <= 1280; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            if (r > 1152) res[127 - (r - 1153)] = z;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            s  = {t3, s[1:92], t2, s[94:176], t1, s[178:287]};
        end
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(output int cycles);
        kin = '0;
        krdy = 1'b1;
        cycles = 0;
        do begin tick(); cycles++; end while (!kvld1 && cycles < 10);
        krdy = 1'b0;
    endtask

    // Starts a run and counts edges from the accepting edge (edge 0) to Dvld of the UNROLL=1 core.
    task automatic run_iv(input logic [79:0] iv, input int stall_at, input bit noise,
                          output int cnt, output logic bsy_start, output logic bsy_done,
                          output int cnt8, output int cnt64);
        din = iv;
        drdy = 1'b1;
        tick();
        bsy_start = bsy1;
        drdy = 1'b0;
        cnt = 0; cnt8 = -1; cnt64 = -1; bsy_done = 1'b1;
        while (cnt < 3000) begin
            tick();
            cnt++;
            if (dvld8 && cnt8 < 0) cnt8 = cnt;
            if (dvld64 && cnt64 < 0) cnt64 = cnt;
            if (dvld1) begin bsy_done = bsy1; break; end
            if (cnt == stall_at) en = 1'b0;
            if (cnt == stall_at + 7) en = 1'b1;
            if (noise && cnt == 100) begin krdy = 1'b1; drdy = 1'b1; kin = '1; din = '1; end
            if (noise && cnt == 104) begin krdy = 1'b0; drdy = 1'b0; kin = '0; din = iv; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; krdy = 1'b0; drdy = 1'b0; encdec = 1'b0; kin = '0; din = '0;
        tick(); tick();
        vectors++; if (dout1 !== 128'h0) begin miscompares++; $display("FAIL reset_dout: got %h want 0", dout1); end
        vectors++; if ({bsy1, bsy8, bsy64} !== 3'b0) begin miscompares++; $display("FAIL reset_bsy: got %b want 000", {bsy1, bsy8, bsy64}); end
        vectors++; if ({kvld1, kvld8, kvld64} !== 3'b0) begin miscompares++; $display("FAIL reset_kvld: got %b want 000", {kvld1, kvld8, kvld64}); end
        vectors++; if ({dvld1, dvld8, dvld64} !== 3'b0) begin miscompares++; $display("FAIL reset_dvld: got %b want 000", {dvld1, dvld8, dvld64}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_drdy_no_key;
        din = iv_basic;
        drdy = 1'b1;
        repeat (3) tick();
        vectors++; if (bsy1 !== 1'b0) begin miscompares++; $display("FAIL nokey_bsy: got %b want 0", bsy1); end
        drdy = 1'b0;
        repeat (3) tick();
        vectors++; if (dvld1 !== 1'b0) begin miscompares++; $display("FAIL nokey_dvld: got %b want 0", dvld1); end
    endtask

    task automatic test_basic;
        load_key(k);
        vectors++; if (k !== 1) begin miscompares++; $display("FAIL basic_kvld_latency: got %0d want 1", k); end
        tick();
        vectors++; if (kvld1 !== 1'b0) begin miscompares++; $display("FAIL basic_kvld_width: got %b want 0", kvld1); end
        run_iv(iv_basic, -100, 1'b0, n, b0, be, n8, n64);
        vectors++; if (b0 !== 1'b1) begin miscompares++; $display("FAIL basic_bsy_rise: got %b want 1", b0); end
        vectors++; if (n !== 1280) begin miscompares++; $display("FAIL basic_dvld_edge: got %0d want 1280", n); end
        vectors++; if (be !== 1'b0) begin miscompares++; $display("FAIL basic_bsy_fall: got %b want 0", be); end
        vectors++; if (dout1 !== exp_basic) begin miscompares++; $display("FAIL basic_dout: got %h want %h", dout1, exp_basic); end
        vectors++; if (n8 !== 160) begin miscompares++; $display("FAIL basic_u8_edge: got %0d want 160", n8); end
        vectors++; if (n64 !== 20) begin miscompares++; $display("FAIL basic_u64_edge: got %0d want 20", n64); end
        vectors++; if (dout8 !== exp_basic) begin miscompares++; $display("FAIL basic_u8_dout: got %h want %h", dout8, exp_basic); end
        vectors++; if (dout64 !== exp_basic) begin miscompares++; $display("FAIL basic_u64_dout: got %h want %h", dout64, exp_basic); end
        tick();
        vectors++; if (dvld1 !== 1'b0) begin miscompares++; $display("FAIL basic_dvld_width: got %b want 0", dvld1); end
        vectors++; if (dout1 !== exp_basic) begin miscompares++; $display("FAIL basic_dout_hold: got %h want %h", dout1, exp_basic); end
    endtask

    task automatic test_tie;
        kin = '0; krdy = 1'b1; drdy = 1'b1; din = ivs[3];
        tick();
        krdy = 1'b0; drdy = 1'b0;
        vectors++; if (kvld1 !== 1'b1) begin miscompares++; $display("FAIL tie_kvld: got %b want 1", kvld1); end
        vectors++; if (bsy1 !== 1'b0) begin miscompares++; $display("FAIL tie_bsy: got %b want 0", bsy1); end
        repeat (2) tick();
        vectors++; if (bsy1 !== 1'b0) begin miscompares++; $display("FAIL tie_bsy_later: got %b want 0", bsy1); end
    endtask

    task automatic test_iv_sweep;
        p = kvld_pulses;
        encdec = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e = model(80'h0, ivs[i]);
            run_iv(ivs[i], -100, 1'b0, n, b0, be, n8, n64);
            vectors++; if (n !== 1280) begin miscompares++; $display("FAIL sweep%0d_edge: got %0d want 1280", i, n); end
            vectors++; if (dout1 !== e) begin miscompares++; $display("FAIL sweep%0d_dout: got %h want %h", i, dout1, e); end
            repeat (3) tick();
        end
        encdec = 1'b0;
        vectors++; if (kvld_pulses !== p) begin miscompares++; $display("FAIL sweep_key_reload: got %0d Kvld pulses want 0", kvld_pulses - p); end
    endtask

    task automatic test_busy_ignore;
        p = kvld_pulses;
        run_iv(iv_basic, -100, 1'b1, n, b0, be, n8, n64);
        vectors++; if (n !== 1280) begin miscompares++; $display("FAIL busy_edge: got %0d want 1280", n); end
        vectors++; if (dout1 !== exp_basic) begin miscompares++; $display("FAIL busy_dout: got %h want %h", dout1, exp_basic); end
        vectors++; if (kvld_pulses !== p) begin miscompares++; $display("FAIL busy_kvld: got %0d pulses want 0", kvld_pulses - p); end
        repeat (2) tick();
        e = model(80'h0, ivs[0]);
        run_iv(ivs[0], -100, 1'b0, n, b0, be, n8, n64);
        vectors++; if (dout1 !== e) begin miscompares++; $display("FAIL busy_key_kept: got %h want %h", dout1, e); end
    endtask

    task automatic test_en_stall;
        tick();
        run_iv(iv_basic, 300, 1'b0, n, b0, be, n8, n64);
        vectors++; if (n !== 1287) begin miscompares++; $display("FAIL stall_edge: got %0d want 1287", n); end
        vectors++; if (be !== 1'b0) begin miscompares++; $display("FAIL stall_bsy_fall: got %b want 0", be); end
        vectors++; if (dout1 !== exp_basic) begin miscompares++; $display("FAIL stall_dout: got %h want %h", dout1, exp_basic); end
    endtask

    task automatic test_reset_mid;
        tick();
        din = ivs[5]; drdy = 1'b1;
        tick();
        drdy = 1'b0;
        repeat (600) tick();
        vectors++; if (bsy1 !== 1'b1) begin miscompares++; $display("FAIL mid_bsy_before: got %b want 1", bsy1); end
        rst = 1'b1;
        #1;
        vectors++; if (dout1 !== 128'h0) begin miscompares++; $display("FAIL mid_dout: got %h want 0", dout1); end
        vectors++; if ({bsy1, kvld1, dvld1} !== 3'b0) begin miscompares++; $display("FAIL mid_flags: got %b want 000", {bsy1, kvld1, dvld1}); end
        tick();
        rst = 1'b0;
        drdy = 1'b1;
        repeat (3) tick();
        drdy = 1'b0;
        vectors++; if (bsy1 !== 1'b0) begin miscompares++; $display("FAIL mid_nokey_bsy: got %b want 0", bsy1); end
    endtask

    task automatic test_unroll;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        load_key(k);
        tick();
        e = model(80'h0, ivs[9]);
        run_iv(ivs[9], -100, 1'b0, n, b0, be, n8, n64);
        vectors++; if (n !== 1280) begin miscompares++; $display("FAIL unroll_u1_edge: got %0d want 1280", n); end
        vectors++; if (n8 !== 160) begin miscompares++; $display("FAIL unroll_u8_edge: got %0d want 160", n8); end
        vectors++; if (n64 !== 20) begin miscompares++; $display("FAIL unroll_u64_edge: got %0d want 20", n64); end
        vectors++; if (dout1 !== e) begin miscompares++; $display("FAIL unroll_u1_dout: got %h want %h", dout1, e); end
        vectors++; if (dout8 !== e) begin miscompares++; $display("FAIL unroll_u8_dout: got %h want %h", dout8, e); end
        vectors++; if (dout64 !== e) begin miscompares++; $display("FAIL unroll_u64_dout: got %h want %h", dout64, e); end
    endtask

    initial begin
        ivs[0] = 80'h06070809000000000000; ivs[1] = 80'h1a2b3c4d000000000000;
        ivs[2] = 80'h00000000000000000001; ivs[3] = 80'hffffffffffffffffffff;
        ivs[4] = 80'h0123456789abcdef0123; ivs[5] = 80'hdeadbeefcafef00d1234;
        ivs[6] = 80'h5555aaaa5555aaaa5555; ivs[7] = 80'h00000000800000000000;
        ivs[8] = 80'h13579bdf2468ace02468; ivs[9] = 80'had793e5a000000000000;
        exp_basic = model(80'h0, iv_basic);
        test_reset();
        test_drdy_no_key();
        test_basic();
        test_tie();
        test_iv_sweep();
        test_busy_ignore();
        test_en_stall();
        test_reset_mid();
        test_unroll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/trivium_keystream_core.md
# trivium_keystream_core

Trivium keystream generator behind the Kin/Din/Krdy/Drdy/Kvld/Dvld/BSY handshake used by the Trivium test benches and the SASEBO checker host. It is the responder end of that interface:
- accepts an 80-bit key, then an 80-bit IV;
- runs the 1152-round Trivium initialisation;
- returns 128 keystream bits on Dout with a Dvld pulse.

EncDec is accepted for interface compatibility only; stream-cipher encryption and decryption are identical.

## Interface
- UNROLL, 1, state-update rounds per clock; legal values 1, 2, 4, 8, 16, 32, 64.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active high.
- EN  in  1  core enable; low freezes all state, counters and outputs.
- Kin  in  80  key; key bit K(i), i=1..80, is Kin[80-i].
- Din  in  80  IV; IV bit IV(i) is Din[80-i].
- Krdy  in  1  key valid request.
- Drdy  in  1  IV valid / start request.
- EncDec  in  1  ignored.
- Dout  out  128  keystream; z1 is Dout[127], z128 is Dout[0].
- BSY  out  1  initialisation or generation in progress.
- Kvld  out  1  one-cycle pulse: key latched.
- Dvld  out  1  one-cycle pulse: Dout valid.

## Operation
- **States:** IDLE, INIT, GEN.
- **Registers:** a 288-bit state s1..s288, an 80-bit key register, a key_loaded flag, and a round counter.
- **Key load.**
  - Condition: IDLE, EN=1, Krdy=1, Kvld=0.
  - Action: latch Kin, set key_loaded, pulse Kvld next cycle.
  - If Krdy is held, the key re-latches every second cycle; this is harmless.
- **Start.**
  - Condition: IDLE, EN=1, Drdy=1, key_loaded=1, and no key load in the same cycle (Krdy wins a tie; that Drdy is ignored).
  - State load: s1..s80=K1..K80, s81..s93=0; s94..s173=IV1..IV80, s174..s177=0; s178..s285=0, s286..s288=1.
  - Then go to INIT and raise BSY.
- **Drdy with key_loaded=0:** ignored; no BSY, no Dvld.
- **Round function** (per round, standard Trivium):
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: s1..s93 ← t3,s1..s92; s94..s177 ← t2,s94..s176; s178..s288 ← t1,s178..s287.
  - UNROLL rounds are chained combinationally per clock.
- **INIT:** 1152/UNROLL clocks, z discarded, then go to GEN.
- **GEN:** 128/UNROLL clocks. Each clock shifts UNROLL z bits into the Dout shift register, MSB first.
  - After the last clock: Dvld pulses, BSY falls, return to IDLE.
- **Dout:** holds its value until the next Start. It does not change while BSY=1 until generation completes; it is loaded directly in the final GEN cycle, with no visible partial values.
- **Key persistence:** the key persists across IV runs; a new Start reuses it.
- **Ignored while BSY=1:** Krdy and Drdy.
- **EN=0 in any state:** everything holds, including BSY and the counter; pulses are not emitted while EN=0 and are deferred until EN returns.
- **Reset:** all registers clear and the FSM returns to IDLE.

## Timing
- **Reset values:** Dout=0, BSY=0, Kvld=0, Dvld=0, key_loaded=0, state=IDLE. Reset is effective immediately (asynchronous) in any state, including mid-INIT or mid-GEN.
- **Kvld:** high for the one cycle after the Krdy-accepting edge.
- **BSY:** high from the edge accepting Drdy (edge 0).
- **Dvld:** rises at edge N = 1152/UNROLL + 128/UNROLL (UNROLL=1: N=1280; UNROLL=64: N=20), the same edge at which BSY falls. Dvld is high for exactly one cycle.
- **Back-to-back:** a new Drdy can be accepted at edge N+1 at the earliest.
- **Clock-count basis:** all counts assume EN=1 throughout; each EN=0 cycle adds one cycle.

## Test plan
- **Basic run:** RST pulse; Kin=0 with Krdy until Kvld; then Din=80'h80000000000000000000 with Drdy until BSY.
  - Kvld pulses one cycle after the Krdy edge; BSY rises next edge.
  - Dvld at edge 1280 (UNROLL=1), with BSY falling the same edge.
  - Dout equals the bench's bit-serial Trivium model, with z1 at Dout[127].
- **Ten-IV sweep:** one key (80'h0), IVs 80'h06070809000000000000 through 80'had793e5a000000000000, 3 idle cycles between runs.
  - Every Dout matches the model.
  - Key is loaded only once.
- **Ignore rules:**
  - Drdy before any Krdy → no BSY.
  - Krdy and Drdy in the same cycle → Kvld only.
  - Krdy/Drdy toggled during BSY → no effect on Dout or latency.
- **EN stall:** deassert EN for 7 cycles mid-INIT → Dvld at edge 1287; Dout unchanged versus the no-stall run.
- **Reset mid-run:** RST at edge 600 of INIT → all outputs 0 immediately; a subsequent Drdy without Krdy is ignored.
- **UNROLL sweep:** repeat the basic run with UNROLL=8 and 64 → Dvld at edges 160 and 20; Dout identical to the UNROLL=1 result.
